// File: rtl/pattern_detect.sv
// pattern_detect
//   Serial receiver/decoder for the 4-bit test-pattern stream. Bits arrive
//   LSB first, one per cycle with s_valid high. Once four bits are in, the
//   word is compared against P1..P4 (in that priority order). The result is
//   held until clr. A frame that stalls for TMO consecutive idle cycles is
//   aborted, and err_tmo pulses for one cycle. Each pattern has its own
//   saturating hit counter, which is cleared only by rst.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   s_in       serial data bit
//   s_valid    s_in is qualified this cycle
//   clr        synchronous frame clear; has priority over s_valid
//   rx_done    frame complete, results valid and held
//   match      received word equals one of P1..P4
//   no_match   received word equals none of the patterns
//   match_add  address of matched pattern (0 when no_match)
//   rx_word    assembled word, bit k = k-th received bit
//   err_tmo    one-cycle pulse on timeout abort
//   hit_cnt    per-pattern hit counters, address 0 in the low CW bits
//   busy       high while a frame is being shifted in
module pattern_detect #(
    parameter logic [3:0] P1  = 4'b1010,
    parameter logic [3:0] P2  = 4'b0101,
    parameter logic [3:0] P3  = 4'b1100,
    parameter logic [3:0] P4  = 4'b0011,
    parameter int         TMO = 8,
    parameter int         CW  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            s_in,
    input  logic            s_valid,
    input  logic            clr,
    output logic            rx_done,
    output logic            match,
    output logic            no_match,
    output logic [1:0]      match_add,
    output logic [3:0]      rx_word,
    output logic            err_tmo,
    output logic [4*CW-1:0] hit_cnt,
    output logic            busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // The idle counter aborts when it would step onto TMO. The abort
    // therefore happens on the TMO-th consecutive idle edge.
    localparam logic [7:0] TMO_LAST = 8'(TMO - 1);

    state_t      state_q, state_d;
    logic [3:0]  rx_word_q, rx_word_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [7:0]  idle_q, idle_d;
    logic        err_tmo_q, err_tmo_d;
    logic        rx_done_q, rx_done_d;
    logic        match_q, match_d;
    logic        no_match_q, no_match_d;
    logic [1:0]  match_add_q, match_add_d;
    logic [3:0]  hit_inc;

    // Word as it will look once the current bit is inserted. The decoder
    // looks at this word, so the result registers on the same edge as the
    // 4th bit.
    logic [3:0]  word_ins;
    logic        dec_match;
    logic [1:0]  dec_add;

    always_comb begin
        word_ins          = rx_word_q;
        word_ins[cnt_q]   = s_in;
    end

    always_comb begin
        dec_match = 1'b1;
        dec_add   = 2'd0;
        if (word_ins == P1) begin
            dec_add = 2'd0;
        end else if (word_ins == P2) begin
            dec_add = 2'd1;
        end else if (word_ins == P3) begin
            dec_add = 2'd2;
        end else if (word_ins == P4) begin
            dec_add = 2'd3;
        end else begin
            dec_match = 1'b0;
        end
    end

    // Next-state and frame datapath
    always_comb begin
        state_d     = state_q;
        rx_word_d   = rx_word_q;
        cnt_d       = cnt_q;
        idle_d      = idle_q;
        err_tmo_d   = 1'b0;
        rx_done_d   = rx_done_q;
        match_d     = match_q;
        no_match_d  = no_match_q;
        match_add_d = match_add_q;
        hit_inc     = 4'b0000;

        case (state_q)
            IDLE: begin
                if (clr) begin
                    rx_word_d = 4'b0000;
                    cnt_d     = 2'd0;
                    idle_d    = 8'd0;
                end else if (s_valid) begin
                    rx_word_d = {3'b000, s_in};
                    cnt_d     = 2'd1;
                    idle_d    = 8'd0;
                    state_d   = SHIFT;
                end
            end

            SHIFT: begin
                if (clr) begin
                    // Abort without a timeout flag. Any bit offered this
                    // cycle is dropped.
                    rx_word_d = 4'b0000;
                    cnt_d     = 2'd0;
                    idle_d    = 8'd0;
                    state_d   = IDLE;
                end else if (s_valid) begin
                    rx_word_d = word_ins;
                    idle_d    = 8'd0;
                    if (cnt_q == 2'd3) begin
                        cnt_d       = 2'd0;
                        state_d     = DONE;
                        rx_done_d   = 1'b1;
                        match_d     = dec_match;
                        no_match_d  = ~dec_match;
                        match_add_d = dec_add;
                        hit_inc[dec_add] = dec_match;
                    end else begin
                        cnt_d = 2'(cnt_q + 2'd1);
                    end
                end else if (idle_q == TMO_LAST) begin
                    err_tmo_d = 1'b1;
                    rx_word_d = 4'b0000;
                    cnt_d     = 2'd0;
                    idle_d    = 8'd0;
                    state_d   = IDLE;
                end else begin
                    idle_d = 8'(idle_q + 8'd1);
                end
            end

            DONE: begin
                if (clr) begin
                    state_d     = IDLE;
                    rx_word_d   = 4'b0000;
                    rx_done_d   = 1'b0;
                    match_d     = 1'b0;
                    no_match_d  = 1'b0;
                    match_add_d = 2'd0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rx_word_q   <= 4'b0000;
            cnt_q       <= 2'd0;
            idle_q      <= 8'd0;
            err_tmo_q   <= 1'b0;
            rx_done_q   <= 1'b0;
            match_q     <= 1'b0;
            no_match_q  <= 1'b0;
            match_add_q <= 2'd0;
        end else begin
            state_q     <= state_d;
            rx_word_q   <= rx_word_d;
            cnt_q       <= cnt_d;
            idle_q      <= idle_d;
            err_tmo_q   <= err_tmo_d;
            rx_done_q   <= rx_done_d;
            match_q     <= match_d;
            no_match_q  <= no_match_d;
            match_add_q <= match_add_d;
        end
    end

    // Per-pattern saturating hit counters
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_hit
            logic [CW-1:0] hit_q, hit_d;

            always_comb begin
                hit_d = hit_q;
                if (hit_inc[gi] && (hit_q != {CW{1'b1}})) begin
                    hit_d = hit_q + 1'b1;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    hit_q <= '0;
                end else begin
                    hit_q <= hit_d;
                end
            end

            assign hit_cnt[gi*CW +: CW] = hit_q;
        end
    endgenerate

    assign rx_done   = rx_done_q;
    assign match     = match_q;
    assign no_match  = no_match_q;
    assign match_add = match_add_q;
    assign rx_word   = rx_word_q;
    assign err_tmo   = err_tmo_q;
    assign busy      = (state_q == SHIFT);

endmodule

// File: tb/tb_pattern_detect.sv
module tb_pattern_detect;

    localparam int CW  = 2;
    localparam int TMO = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            s_in;
    logic            s_valid;
    logic            clr;
    logic            rx_done;
    logic            match;
    logic            no_match;
    logic [1:0]      match_add;
    logic [3:0]      rx_word;
    logic            err_tmo;
    logic [4*CW-1:0] hit_cnt;
    logic            busy;

    always #5 clk = ~clk;

    pattern_detect #(.TMO(TMO), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .s_in      (s_in),
        .s_valid   (s_valid),
        .clr       (clr),
        .rx_done   (rx_done),
        .match     (match),
        .no_match  (no_match),
        .match_add (match_add),
        .rx_word   (rx_word),
        .err_tmo   (err_tmo),
        .hit_cnt   (hit_cnt),
        .busy      (busy)
    );

    typedef struct {
        logic [3:0] bits;
        logic       exp_match;
        logic [1:0] exp_add;
    } vec_t;

    typedef struct {
        logic            exp_match;
        logic [1:0]      exp_add;
        logic [3:0]      exp_word;
        logic [4*CW-1:0] exp_hits;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   hit_m[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4*CW-1:0] hits_packed();
        logic [4*CW-1:0] r;
        for (int i = 0; i < 4; i++) r[i*CW +: CW] = CW'(hit_m[i]);
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) hit_m[i] = 0;
    endtask

    task automatic push_exp(input logic m, input logic [1:0] a, input logic [3:0] w);
        exp_t e;
        if (m && hit_m[a] < (1 << CW) - 1) hit_m[a]++;
        e.exp_match = m;
        e.exp_add   = m ? a : 2'd0;
        e.exp_word  = w;
        e.exp_hits  = hits_packed();
        sb.push_back(e);
    endtask

    // Called one step after the 4th-bit edge: results must already be there.
    task automatic pop_compare(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_scoreboard: got empty queue expected one entry", tag);
            return;
        end
        e = sb.pop_front();
        $display("frame %s word=%b done=%0b match=%0b no_match=%0b add=%0d hits=%h",
                 tag, rx_word, rx_done, match, no_match, match_add, hit_cnt);
        check({tag, "_rx_done"},   32'(rx_done),   32'd1);
        check({tag, "_match"},     32'(match),     32'(e.exp_match));
        check({tag, "_no_match"},  32'(no_match),  32'(!e.exp_match));
        check({tag, "_match_add"}, 32'(match_add), 32'(e.exp_add));
        check({tag, "_rx_word"},   32'(rx_word),   32'(e.exp_word));
        check({tag, "_hit_cnt"},   32'(hit_cnt),   32'(e.exp_hits));
        check({tag, "_busy"},      32'(busy),      32'd0);
    endtask

    task automatic send_frame(input string tag, input logic [3:0] bits,
                              input logic m, input logic [1:0] a);
        logic [3:0] mask;
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1;
            s_in    = bits[i];
            if (i == 3) push_exp(m, a, bits);
            step();
            if (i < 3) begin
                mask = 4'((1 << (i + 1)) - 1);
                check({tag, "_busy_shift"}, 32'(busy),    32'd1);
                check({tag, "_partial"},    32'(rx_word), 32'(bits & mask));
            end
        end
        s_valid = 1'b0;
        s_in    = 1'b0;
        pop_compare(tag);
    endtask

    task automatic do_clr();
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("clr_rx_done", 32'(rx_done), 32'd0);
        check("clr_match",   32'({match, no_match, match_add}), 32'd0);
        check("clr_rx_word", 32'(rx_word), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_outs"}, 32'({rx_done, match, no_match, match_add, rx_word, err_tmo, busy}), 32'd0);
        check({tag, "_hits"}, 32'(hit_cnt), 32'd0);
    endtask

    initial begin
        vec_t       vecs[6];
        int         sat_exp[5];
        logic [3:0] gen_pat;

        vecs[0] = '{bits: 4'b1100, exp_match: 1'b1, exp_add: 2'd2};
        vecs[1] = '{bits: 4'b1111, exp_match: 1'b0, exp_add: 2'd0};
        vecs[2] = '{bits: 4'b1010, exp_match: 1'b1, exp_add: 2'd0};
        vecs[3] = '{bits: 4'b0101, exp_match: 1'b1, exp_add: 2'd1};
        vecs[4] = '{bits: 4'b0011, exp_match: 1'b1, exp_add: 2'd3};
        vecs[5] = '{bits: 4'b0000, exp_match: 1'b0, exp_add: 2'd0};
        sat_exp = '{1, 2, 3, 3, 3};
        gen_pat = 4'b0101;

        rst = 1'b1; s_in = 1'b0; s_valid = 1'b0; clr = 1'b0;
        model_reset();
        #2;
        check_all_zero("reset");
        step();
        rst = 1'b0;

        // Table-driven frames
        for (int v = 0; v < 6; v++) begin
            send_frame($sformatf("vec%0d", v), vecs[v].bits, vecs[v].exp_match, vecs[v].exp_add);
            do_clr();
        end

        // Stall: 2 bits, then TMO idle cycles
        s_valid = 1'b1; s_in = 1'b0; step();
        s_in = 1'b1; step();
        s_valid = 1'b0;
        for (int k = 1; k <= TMO; k++) begin
            step();
            if (k < TMO) begin
                check("tmo_early_err", 32'(err_tmo), 32'd0);
                check("tmo_early_busy", 32'(busy), 32'd1);
            end
        end
        $display("timeout err_tmo=%0b busy=%0b word=%b", err_tmo, busy, rx_word);
        check("tmo_err", 32'(err_tmo), 32'd1);
        check("tmo_idle", 32'({busy, rx_done}), 32'd0);
        check("tmo_word", 32'(rx_word), 32'd0);
        step();
        check("tmo_pulse_width", 32'(err_tmo), 32'd0);

        // TMO-1 idle cycles mid-frame must not abort
        s_valid = 1'b1; s_in = 1'b0; step();
        s_in = 1'b1; step();
        s_valid = 1'b0;
        for (int k = 0; k < TMO - 1; k++) begin
            step();
            check("near_tmo_err", 32'(err_tmo), 32'd0);
        end
        s_valid = 1'b1; s_in = 1'b0; step();
        s_in = 1'b1;
        push_exp(1'b1, 2'd0, 4'b1010);
        step();
        s_valid = 1'b0;
        pop_compare("near_tmo");
        do_clr();

        // clr with a valid bit mid-frame: bit dropped, no timeout flag
        s_valid = 1'b1; s_in = 1'b1; step();
        clr = 1'b1; s_in = 1'b0; step();
        clr = 1'b0; s_valid = 1'b0;
        check("clr_abort_busy", 32'(busy), 32'd0);
        check("clr_abort_word", 32'(rx_word), 32'd0);
        check("clr_abort_err",  32'(err_tmo), 32'd0);
        send_frame("after_clr", 4'b0101, 1'b1, 2'd1);
        do_clr();

        // Asynchronous reset mid-frame
        s_valid = 1'b1; s_in = 1'b1; step();
        step();
        s_in = 1'b0; step();
        rst = 1'b1;
        #1;
        model_reset();
        check_all_zero("mid_reset");
        step();
        rst = 1'b0; s_valid = 1'b0;
        send_frame("post_reset_p4", 4'b0011, 1'b1, 2'd3);
        do_clr();

        // Saturation of counter 0
        for (int k = 0; k < 5; k++) begin
            send_frame($sformatf("sat%0d", k), 4'b1010, 1'b1, 2'd0);
            check($sformatf("sat%0d_cnt0", k), 32'(hit_cnt[CW-1:0]), 32'(sat_exp[k]));
            do_clr();
        end

        // Loopback: generator and receiver leave reset together
        rst = 1'b1; s_valid = 1'b1; s_in = gen_pat[0];
        step();
        rst = 1'b0;
        model_reset();
        for (int k = 0; k < 4; k++) begin
            s_in = gen_pat[k];
            if (k == 3) push_exp(1'b1, 2'd1, 4'b0101);
            step();
        end
        pop_compare("loopback");
        for (int k = 0; k < 10; k++) begin
            s_in = gen_pat[k % 4];
            step();
            check("loopback_hold_done", 32'(rx_done), 32'd1);
            check("loopback_hold_word", 32'({rx_word, match_add}), 32'({4'b0101, 2'd1}));
        end
        s_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pattern_detect.md
Name: pattern_detect

Overview:
- Serial receiver and decoder for the 4-bit test-pattern stream produced by the team's pattern generator.
- Shifts in 4 bits, LSB first, one bit per qualified clock.
- Identifies which of the four fixed patterns was received and reports its 2-bit address, or flags no match.
- Keeps a saturating hit counter per pattern and aborts a stalled frame after a programmable timeout.

Parameters:
- P1, 4'b1010, pattern for address 0
- P2, 4'b0101, pattern for address 1
- P3, 4'b1100, pattern for address 2
- P4, 4'b0011, pattern for address 3
- TMO, 8, maximum number of consecutive idle cycles allowed inside a frame before it is aborted (valid range 1..255)
- CW, 4, width of each per-pattern hit counter

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- s_in  in  1  serial data bit
- s_valid  in  1  s_in is qualified this cycle
- clr  in  1  synchronous frame clear: returns the block to IDLE and drops the result
- rx_done  out  1  frame complete; result outputs are valid and held
- match  out  1  received word equals one of P1..P4
- no_match  out  1  received word equals none of the patterns
- match_add  out  2  address of the matched pattern (0..3); 0 when no_match
- rx_word  out  4  assembled word, bit k = k-th received bit
- err_tmo  out  1  one-cycle pulse when a frame is aborted by timeout
- hit_cnt  out  4*CW  concatenated hit counters; [CW-1:0] is address 0, up to [4*CW-1:3*CW] for address 3
- busy  out  1  high in SHIFT

Behaviour:
- Reset: async on rst high. All outputs, counters and the shift register go to 0; state goes to IDLE.
- States and transitions:
  - IDLE: on s_valid=1, capture s_in into rx_word[0], set bit count=1 and go to SHIFT. Otherwise hold.
  - SHIFT: on s_valid=1, capture s_in into rx_word[count] and increment count. When the 4th bit is captured (count was 3), go to DONE.
  - SHIFT with s_valid=0: increment the idle counter; any valid bit resets the idle counter to 0. When the idle counter reaches TMO, pulse err_tmo for 1 cycle, clear rx_word and count, and go to IDLE.
  - DONE: hold all results; ignore s_valid. On clr=1, go to IDLE, clear rx_done, match, no_match, match_add and rx_word.
- Latency: the 4th-bit capture edge also registers the decode. rx_done, match, no_match, match_add and rx_word are valid in the cycle immediately following that edge, with no extra cycle.
- Decode:
  - Compare the full 4-bit word against P1..P4 in that priority order.
  - Exactly one of match or no_match is high while rx_done=1; both are low otherwise.
- Counters:
  - On entry to DONE with match=1, hit_cnt[match_add] increments by 1 and saturates at 2^CW-1.
  - Counters are cleared only by rst; clr does not affect them.
- busy=1 only in SHIFT. rx_word shows partial bits during SHIFT.
- clr in IDLE or SHIFT:
  - Aborts the frame and goes to IDLE, with no err_tmo.
  - clr has priority over s_valid in the same cycle; that bit is discarded.
- Generator compatibility: with s_valid tied high, the first bit is sampled on the first edge after reset release. After rx_done, further bits are ignored until clr.
- Reset mid-frame: immediate return to IDLE; partial bits and counters are lost.

Test Plan:
- P3 frame: s_valid=1, s_in=0,0,1,1 on consecutive cycles -> the cycle after the 4th bit shows rx_done=1, match=1, match_add=2, rx_word=4'b1100, hit_cnt[3*CW-1:2*CW]=1, busy=0.
- Non-pattern: bits 1,1,1,1 -> rx_done=1, no_match=1, match=0, match_add=0, rx_word=4'b1111, all hit counters unchanged.
- Stall and timeout: 2 valid bits, then s_valid=0 for TMO=8 cycles -> err_tmo high for exactly 1 cycle on the 8th idle cycle, state IDLE, rx_word=0. A separate run with 7 idle cycles then bits 0,1 completes P1 with match_add=0.
- Clear and saturation: CW=2, send P1 five times with clr between frames -> hit counter 0 reads 1,2,3,3,3. A bit driven with clr=1 in the same cycle is discarded, and the next frame still decodes correctly.
- Reset mid-frame: assert rst after 3 bits -> all outputs and counters are 0 asynchronously. The next full P4 frame (1,1,0,0) gives match_add=3.
- Loopback: pattern generator s_out to s_in, add=1, s_valid=1, both reset together -> rx_done rises with match_add=1, rx_word=4'b0101, and stays held indefinitely.
